// File: rtl/bumpy_motion_pkg.sv
// Shared types, fixed-point constants and arithmetic helpers for the Bumpy motion responder.
package bumpy_motion_pkg;

    typedef enum logic [1:0] {
        ST_FALLING  = 2'd0,
        ST_STANDING = 2'd1,
        ST_JUMPING  = 2'd2
    } motion_state_t;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT               = 6;
    localparam int POS_W                  = 17;
    localparam int SPD_W                  = 11;
    localparam int PIX_W                  = POS_W - FP_SHIFT;

    function automatic logic signed [SPD_W-1:0] abs_spd(input logic signed [SPD_W-1:0] v);
        if (v[SPD_W-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Adds gravity in a widened sum so the ceiling test cannot wrap.
    function automatic logic signed [SPD_W-1:0] add_gravity(
        input logic signed [SPD_W-1:0] v,
        input logic signed [SPD_W-1:0] g,
        input logic signed [SPD_W-1:0] vmax
    );
        logic signed [SPD_W:0] s;
        logic signed [SPD_W:0] lim;
        s   = {v[SPD_W-1], v} + {g[SPD_W-1], g};
        lim = {vmax[SPD_W-1], vmax};
        if (s > lim) begin
            return vmax;
        end else begin
            return s[SPD_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bumpy_motion_responder_collision_frame_latch.sv
// Per-frame sticky collision flags; the effective flags fold in the current cycle's inputs.
module collision_frame_latch (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sof,
    input  logic i_wall,
    input  logic i_plat,
    input  logic i_trans,
    output logic o_eff_wall,
    output logic o_eff_plat,
    output logic o_eff_trans,
    output logic o_prev_wall
);

    logic r_hit_wall;
    logic r_hit_plat;
    logic r_hit_trans;
    logic r_prev_wall;

    assign o_eff_wall  = r_hit_wall  | i_wall;
    assign o_eff_plat  = r_hit_plat  | i_plat;
    assign o_eff_trans = r_hit_trans | i_trans;
    assign o_prev_wall = r_prev_wall;

    // Accumulate during the frame, clear at frame start and remember the closing wall flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hit_wall  <= 1'b0;
            r_hit_plat  <= 1'b0;
            r_hit_trans <= 1'b0;
            r_prev_wall <= 1'b0;
        end else if (i_sof) begin
            r_hit_wall  <= 1'b0;
            r_hit_plat  <= 1'b0;
            r_hit_trans <= 1'b0;
            r_prev_wall <= o_eff_wall;
        end else begin
            r_hit_wall  <= r_hit_wall  | i_wall;
            r_hit_plat  <= r_hit_plat  | i_plat;
            r_hit_trans <= r_hit_trans | i_trans;
            r_prev_wall <= r_prev_wall;
        end
    end

endmodule

// File: rtl/bumpy_motion_responder.sv
// Resolves a frame's collisions into Bumpy's motion state, speeds and published pixel position.
module bumpy_motion_responder
    import bumpy_motion_pkg::*;
#(
    parameter int INIT_X         = 280,
    parameter int INIT_Y         = 100,
    parameter int INIT_SPEED_X   = 64,
    parameter int JUMP_SPEED     = 320,
    parameter int GRAVITY        = 16,
    parameter int MAX_FALL_SPEED = 448,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 607,
    parameter int Y_MAX          = 447
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    collision_bumpy_wall,
    input  logic                    collision_bumpy_platform,
    input  logic                    collision_bumpy_transplatform,
    input  logic                    jump_key,
    output logic signed [PIX_W-1:0] topLeftX,
    output logic signed [PIX_W-1:0] topLeftY,
    output logic [1:0]              motion_state,
    output logic                    frame_hit
);

    localparam logic [1:0] S_FALLING  = ST_FALLING;
    localparam logic [1:0] S_STANDING = ST_STANDING;
    localparam logic [1:0] S_JUMPING  = ST_JUMPING;

    localparam logic signed [SPD_W-1:0] C_GRAVITY  = SPD_W'(GRAVITY);
    localparam logic signed [SPD_W-1:0] C_JUMP_UP  = SPD_W'(-JUMP_SPEED);
    localparam logic signed [SPD_W-1:0] C_MAX_FALL = SPD_W'(MAX_FALL_SPEED);
    localparam logic signed [SPD_W-1:0] C_INIT_SX  = SPD_W'(INIT_SPEED_X);
    localparam logic signed [POS_W-1:0] C_INIT_PX  = POS_W'(INIT_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [POS_W-1:0] C_INIT_PY  = POS_W'(INIT_Y * FIXED_POINT_MULTIPLIER);
    localparam logic signed [POS_W:0]   C_X_LO_W   = (POS_W+1)'(X_MIN * FIXED_POINT_MULTIPLIER);
    localparam logic signed [POS_W:0]   C_X_HI_W   = (POS_W+1)'(X_MAX * FIXED_POINT_MULTIPLIER);
    localparam logic signed [POS_W:0]   C_Y_HI_W   = (POS_W+1)'(Y_MAX * FIXED_POINT_MULTIPLIER);

    logic signed [POS_W-1:0] r_pos_x;
    logic signed [POS_W-1:0] r_pos_y;
    logic signed [SPD_W-1:0] r_speed_x;
    logic signed [SPD_W-1:0] r_speed_y;
    logic [1:0]              r_state;
    logic                    r_frame_hit;

    logic w_eff_wall, w_eff_plat, w_eff_trans, w_prev_wall;
    logic w_support, w_wall_edge, w_land, w_bump;
    logic [1:0]              w_st_fsm, w_st_n;
    logic signed [SPD_W-1:0] w_sy_base, w_sy_fsm, w_sy_n, w_sx_bnc, w_sx_n;
    logic signed [POS_W:0]   w_x_sum, w_y_sum;
    logic signed [POS_W-1:0] w_x_n, w_y_n;

    collision_frame_latch u_latch (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_sof       (startOfFrame),
        .i_wall      (collision_bumpy_wall),
        .i_plat      (collision_bumpy_platform),
        .i_trans     (collision_bumpy_transplatform),
        .o_eff_wall  (w_eff_wall),
        .o_eff_plat  (w_eff_plat),
        .o_eff_trans (w_eff_trans),
        .o_prev_wall (w_prev_wall)
    );

    assign w_support   = w_eff_plat | w_eff_trans;
    assign w_wall_edge = w_eff_wall & ~w_prev_wall;
    assign w_sx_bnc    = w_wall_edge ? -r_speed_x : r_speed_x;

    // Vertical state machine: landing and head bump are resolved before gravity.
    always_comb begin
        w_land    = 1'b0;
        w_bump    = 1'b0;
        w_st_fsm  = r_state;
        w_sy_base = r_speed_y;
        w_sy_fsm  = r_speed_y;
        case (r_state)
            S_FALLING: begin
                if (w_support && !r_speed_y[SPD_W-1]) begin
                    w_land   = 1'b1;
                    w_sy_fsm = {SPD_W{1'b0}};
                    w_st_fsm = S_STANDING;
                end else begin
                    w_sy_fsm = add_gravity(r_speed_y, C_GRAVITY, C_MAX_FALL);
                    w_st_fsm = S_FALLING;
                end
            end
            S_STANDING: begin
                if (jump_key) begin
                    w_sy_fsm = C_JUMP_UP;
                    w_st_fsm = S_JUMPING;
                end else if (!w_support) begin
                    w_sy_fsm = C_GRAVITY;
                    w_st_fsm = S_FALLING;
                end else begin
                    w_sy_fsm = {SPD_W{1'b0}};
                    w_st_fsm = S_STANDING;
                end
            end
            S_JUMPING: begin
                if (w_eff_plat && r_speed_y[SPD_W-1]) begin
                    w_bump    = 1'b1;
                    w_sy_base = {SPD_W{1'b0}};
                end else begin
                    w_sy_base = r_speed_y;
                end
                w_sy_fsm = add_gravity(w_sy_base, C_GRAVITY, C_MAX_FALL);
                if (!w_sy_fsm[SPD_W-1]) begin
                    w_st_fsm = S_FALLING;
                end else begin
                    w_st_fsm = S_JUMPING;
                end
            end
            default: begin
                w_sy_fsm = r_speed_y;
                w_st_fsm = S_FALLING;
            end
        endcase
    end

    assign w_x_sum = {r_pos_x[POS_W-1], r_pos_x} + {{(POS_W+1-SPD_W){w_sx_bnc[SPD_W-1]}}, w_sx_bnc};
    assign w_y_sum = {r_pos_y[POS_W-1], r_pos_y} + {{(POS_W+1-SPD_W){w_sy_fsm[SPD_W-1]}}, w_sy_fsm};

    // Playfield clamping; hitting the floor doubles as a landing on the bottom edge.
    always_comb begin
        w_x_n  = w_x_sum[POS_W-1:0];
        w_sx_n = w_sx_bnc;
        w_y_n  = w_y_sum[POS_W-1:0];
        w_sy_n = w_sy_fsm;
        w_st_n = w_st_fsm;
        if (w_x_sum < C_X_LO_W) begin
            w_x_n  = C_X_LO_W[POS_W-1:0];
            w_sx_n = abs_spd(w_sx_bnc);
        end else if (w_x_sum > C_X_HI_W) begin
            w_x_n  = C_X_HI_W[POS_W-1:0];
            w_sx_n = -abs_spd(w_sx_bnc);
        end else begin
            w_x_n  = w_x_sum[POS_W-1:0];
            w_sx_n = w_sx_bnc;
        end
        if (w_y_sum > C_Y_HI_W) begin
            w_y_n  = C_Y_HI_W[POS_W-1:0];
            w_sy_n = {SPD_W{1'b0}};
            w_st_n = S_STANDING;
        end else if (w_y_sum[POS_W]) begin
            w_y_n  = {POS_W{1'b0}};
            w_sy_n = w_sy_fsm;
            w_st_n = w_st_fsm;
        end else begin
            w_y_n  = w_y_sum[POS_W-1:0];
            w_sy_n = w_sy_fsm;
            w_st_n = w_st_fsm;
        end
    end

    // Commit the frame's decision on startOfFrame; outputs hold for the rest of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x     <= C_INIT_PX;
            r_pos_y     <= C_INIT_PY;
            r_speed_x   <= C_INIT_SX;
            r_speed_y   <= {SPD_W{1'b0}};
            r_state     <= S_FALLING;
            r_frame_hit <= 1'b0;
        end else if (startOfFrame) begin
            r_pos_x     <= w_x_n;
            r_pos_y     <= w_y_n;
            r_speed_x   <= w_sx_n;
            r_speed_y   <= w_sy_n;
            r_state     <= w_st_n;
            r_frame_hit <= w_land | w_bump | w_wall_edge;
        end else begin
            r_frame_hit <= 1'b0;
        end
    end

    assign topLeftX     = r_pos_x[POS_W-1:FP_SHIFT];
    assign topLeftY     = r_pos_y[POS_W-1:FP_SHIFT];
    assign motion_state = r_state;
    assign frame_hit    = r_frame_hit;

endmodule
